// File: rtl/seg_display_if.sv
// Bundles the requester inputs and the dual-bank display outputs of the display arbiter.
// The master drives requests and segment data; the slave is the arbiter.
interface seg_display_if;
  logic [2:0]  req;
  logic [95:0] left_data;
  logic [95:0] right_data;
  logic [7:0]  seg;
  logic [7:0]  seg1;
  logic [3:0]  an;
  logic [3:0]  an_right;
  logic [2:0]  grant;

  modport master (
    output req, left_data, right_data,
    input  seg, seg1, an, an_right, grant
  );

  modport slave (
    input  req, left_data, right_data,
    output seg, seg1, an, an_right, grant
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that time-shares a multiplexed dual-bank 4-digit display between three
// requesters, with a minimum hold time per owner and a one-slot blank between owners.
module seg_display_arbiter #(
  parameter int unsigned REFRESH_DIV = 200000,
  parameter int unsigned HOLD_FRAMES = 250
) (
  input logic          clk,
  input logic          reset,
  seg_display_if.slave bus
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FrW  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [FrW-1:0]  FrMax  = FrW'(HOLD_FRAMES);

  typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      digit_q;
  logic [FrW-1:0]  frames_q;
  logic [1:0]      owner_q;
  logic [1:0]      last_owner_q;

  logic           tick;
  logic           frame_end;
  logic           hold_done;
  logic           owner_req;
  logic           others_req;
  logic [FrW-1:0] frames_inc;
  logic [1:0]     winner;
  logic [2:0]     owner_oh;
  logic [6:0]     sel;

  function automatic logic [1:0] next3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search order is last+1, last+2, last (mod 3).
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = next3(last);
    c2 = next3(c1);
    if (r[c1]) return c1;
    if (r[c2]) return c2;
    return last;
  endfunction

  always_comb begin
    tick       = (cnt_q == CntMax);
    frame_end  = tick && (digit_q == 2'd3);
    frames_inc = (frames_q >= FrMax) ? frames_q : frames_q + FrW'(1);
    hold_done  = (frames_inc >= FrMax);
    owner_oh   = 3'b001 << owner_q;
    owner_req  = |(bus.req & owner_oh);
    others_req = |(bus.req & ~owner_oh);
    winner     = rr_pick(last_owner_q, bus.req);
    // Byte offset of (owner, digit) within the packed 96-bit data buses.
    sel        = {owner_q, digit_q, 3'b000};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      digit_q      <= '0;
      frames_q     <= '0;
      owner_q      <= '0;
      last_owner_q <= 2'd2;
      bus.seg      <= '0;
      bus.seg1     <= '0;
      bus.an       <= '0;
      bus.an_right <= '0;
      bus.grant    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.seg      <= '0;
          bus.seg1     <= '0;
          bus.an       <= '0;
          bus.an_right <= '0;
          bus.grant    <= '0;
          if (|bus.req) begin
            state_q   <= StActive;
            owner_q   <= winner;
            bus.grant <= 3'b001 << winner;
            cnt_q     <= '0;
            digit_q   <= '0;
            frames_q  <= '0;
          end
        end

        StActive: begin
          // Losing the owner's request always wins over the hold logic.
          if (!owner_req || (frame_end && hold_done && others_req)) begin
            state_q      <= StBlank;
            last_owner_q <= owner_q;
            bus.grant    <= '0;
            cnt_q        <= '0;
            digit_q      <= '0;
            bus.seg      <= '0;
            bus.seg1     <= '0;
            bus.an       <= '0;
            bus.an_right <= '0;
          end else begin
            bus.seg      <= bus.left_data[sel +: 8];
            bus.seg1     <= bus.right_data[sel +: 8];
            bus.an       <= 4'b0001 << digit_q;
            bus.an_right <= 4'b0001 << digit_q;
            cnt_q        <= tick ? '0 : cnt_q + CntW'(1);
            if (tick) digit_q <= digit_q + 2'd1;
            if (frame_end) frames_q <= frames_inc;
          end
        end

        StBlank: begin
          bus.seg      <= '0;
          bus.seg1     <= '0;
          bus.an       <= '0;
          bus.an_right <= '0;
          bus.grant    <= '0;
          if (tick) begin
            cnt_q <= '0;
            if (|bus.req) begin
              state_q   <= StActive;
              owner_q   <= winner;
              bus.grant <= 3'b001 << winner;
              digit_q   <= '0;
              frames_q  <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with REFRESH_DIV=4, HOLD_FRAMES=2 (16-cycle frames).
module tb_seg_display_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  seg_display_if bus ();

  seg_display_arbiter #(
    .REFRESH_DIV(4),
    .HOLD_FRAMES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    int         n;
    logic [2:0] grant;
    logic [3:0] an;
    logic [7:0] seg;
    logic [7:0] seg1;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [2:0] g, input logic [3:0] a,
                            input logic [7:0] s, input logic [7:0] s1);
    check(name, {5'd0, bus.grant, bus.an, bus.an_right, bus.seg, bus.seg1},
          {5'd0, g, a, a, s, s1});
  endtask

  // Number of consecutive sampled cycles grant stays at g, starting with the current one.
  task automatic count_run(input logic [2:0] g, input int limit, output int n);
    n = 0;
    while (bus.grant === g && n < limit) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  run;
    bit  ok_g;
    bit  ok_an;

    vecs[0]  = '{3'b001, 1, 3'b001, 4'b0000, 8'h00, 8'h00};
    vecs[1]  = '{3'b001, 4, 3'b001, 4'b0001, 8'h10, 8'h20};
    vecs[2]  = '{3'b001, 4, 3'b001, 4'b0010, 8'h11, 8'h21};
    vecs[3]  = '{3'b001, 4, 3'b001, 4'b0100, 8'h12, 8'h22};
    vecs[4]  = '{3'b001, 4, 3'b001, 4'b1000, 8'h13, 8'h23};
    vecs[5]  = '{3'b001, 1, 3'b001, 4'b0001, 8'h10, 8'h20};
    vecs[6]  = '{3'b000, 4, 3'b000, 4'b0000, 8'h00, 8'h00};
    vecs[7]  = '{3'b000, 2, 3'b000, 4'b0000, 8'h00, 8'h00};
    vecs[8]  = '{3'b010, 1, 3'b010, 4'b0000, 8'h00, 8'h00};
    vecs[9]  = '{3'b010, 4, 3'b010, 4'b0001, 8'h40, 8'h50};
    vecs[10] = '{3'b010, 2, 3'b010, 4'b0010, 8'h41, 8'h51};
    vecs[11] = '{3'b001, 4, 3'b000, 4'b0000, 8'h00, 8'h00};
    vecs[12] = '{3'b001, 1, 3'b001, 4'b0000, 8'h00, 8'h00};
    vecs[13] = '{3'b001, 4, 3'b001, 4'b0001, 8'h10, 8'h20};

    reset          = 1'b1;
    bus.req        = 3'b000;
    bus.left_data  = {32'h73727170, 32'h43424140, 32'h13121110};
    bus.right_data = {32'h83828180, 32'h53525150, 32'h23222120};
    step();
    step();
    check_outs("reset_state", 3'b000, 4'b0000, 8'h00, 8'h00);
    reset = 1'b0;
    step();
    check_outs("idle_no_req", 3'b000, 4'b0000, 8'h00, 8'h00);

    // Scan, drop-to-blank, idle, re-arbitration after a mid-digit drop.
    for (int i = 0; i < 14; i++) begin
      bus.req = vecs[i].req;
      for (int c = 0; c < vecs[i].n; c++) begin
        step();
        check_outs($sformatf("vec%0d_c%0d", i, c), vecs[i].grant, vecs[i].an, vecs[i].seg,
                   vecs[i].seg1);
      end
    end

    // Asynchronous reset during digit 2, then owner 2 alone.
    repeat (5) step();
    check("an_digit2", {28'd0, bus.an}, 32'h4);
    reset = 1'b1;
    #1;
    check_outs("async_reset", 3'b000, 4'b0000, 8'h00, 8'h00);
    bus.req = 3'b100;
    step();
    reset = 1'b0;
    step();
    check_outs("post_reset_grant", 3'b100, 4'b0000, 8'h00, 8'h00);
    step();
    check_outs("post_reset_disp", 3'b100, 4'b0001, 8'h70, 8'h80);

    // Sole requester keeps the display past the hold with no blank slot.
    ok_g  = 1'b1;
    ok_an = 1'b1;
    for (int c = 0; c < 176; c++) begin
      step();
      if (bus.grant !== 3'b100) ok_g = 1'b0;
      if (bus.an === 4'b0000) ok_an = 1'b0;
    end
    check("hold_forever_grant", {31'd0, ok_g}, 32'd1);
    check("hold_forever_no_gap", {31'd0, ok_an}, 32'd1);

    bus.left_data[95:64] = {4{8'hA5}};
    step();
    check("live_data", {24'd0, bus.seg}, 32'hA5);
    bus.left_data[95:64] = 32'h73727170;

    bus.req = 3'b000;
    repeat (6) step();
    check_outs("back_to_idle", 3'b000, 4'b0000, 8'h00, 8'h00);

    // Hold expiry with a pending requester, then full rotation with all requesting.
    bus.req = 3'b011;
    step();
    count_run(3'b001, 100, run);
    check("run_owner0", run, 32);
    count_run(3'b000, 100, run);
    check("blank_0to1", run, 4);
    check("grant_owner1", {29'd0, bus.grant}, 32'h2);
    bus.req = 3'b111;
    count_run(3'b010, 100, run);
    check("run_owner1", run, 32);
    count_run(3'b000, 100, run);
    check("blank_1to2", run, 4);
    count_run(3'b100, 100, run);
    check("run_owner2", run, 32);
    count_run(3'b000, 100, run);
    check("blank_2to0", run, 4);
    check("grant_wrap0", {29'd0, bus.grant}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
